imem_load_arbiter: RTL and testbench
====================================

Name: imem_load_arbiter

Overview:
- Owns the single instruction-memory port and shares it between the pipeline fetch stage (read) and a program loader (write, word by word).
- Sequences reload: stalls the CPU, streams words into memory from address 0, then pulses a restart so the pipeline refetches from PC 0.
- Sits between the IF stage / loader interface and the instruction memory array. The array is combinational-read; this block registers the read data.

Parameters:
- ADDR_W, 10, word-address width (byte address bits [11:2]).
- DATA_W, 32, instruction width.
- DEPTH, 1024, number of words in the memory; also the upper clamp for load length.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  IF stage requests a read.
- fetch_addr  in  ADDR_W  word address of the requested read.
- fetch_gnt  out  1  request accepted this cycle.
- fetch_valid  out  1  fetch_data valid; asserted the cycle after the grant.
- fetch_data  out  DATA_W  registered instruction.
- cpu_stall  out  1  holds the pipeline while high.
- cpu_restart  out  1  one-cycle pulse: the pipeline resets PC to 0 and flushes.
- ld_start  in  1  begin a load; sampled only in RUN.
- ld_len  in  ADDR_W+1  number of words to load; captured on ld_start.
- ld_valid  in  1  ld_data valid.
- ld_data  in  DATA_W  word to write.
- ld_ready  out  1  block accepts ld_data.
- ld_done  out  1  one-cycle pulse at load completion.
- ld_checksum  out  DATA_W  see Optional Feature.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  combinational read data from memory.

Behaviour:
- Reset values: state=RUN, wr_ptr=0, len_q=0, fetch_gnt=0, fetch_valid=0, fetch_data=0, cpu_stall=0, cpu_restart=0, ld_ready=0, ld_done=0, ld_checksum=0, mem_we=0.
- Reset mid-load returns to RUN immediately. Memory contents are left as-is; no restart pulse is issued.

State RUN:
- mem_addr=fetch_addr and fetch_gnt=fetch_req, except when ld_start=1, in which case fetch_gnt=0 (loader has priority).
- On a grant, fetch_data<=mem_rdata and fetch_valid<=1 at the next edge. Otherwise fetch_valid<=0. Latency is exactly 1 cycle.
- On ld_start=1: len_q<=min(ld_len, DEPTH), wr_ptr<=0, go to LOAD.
- If the clamped length is 0, go to FLUSH instead of LOAD.

State LOAD:
- cpu_stall=1, ld_ready=1, fetch_gnt=0, fetch_valid=0.
- mem_addr=wr_ptr, mem_wdata=ld_data, mem_we=ld_valid.
- On ld_valid && ld_ready, wr_ptr increments.
- When wr_ptr+1==len_q on an accepted word, go to FLUSH; that last word is written in the same cycle.
- ld_start is ignored while in LOAD.
- ld_valid=0 stalls indefinitely; there is no timeout.

State FLUSH (1 cycle):
- cpu_stall=1, ld_ready=0, mem_we=0, ld_done=1, cpu_restart=1. Next state is RUN.
- fetch_valid is forced 0 on the first RUN cycle after FLUSH, so no stale data is delivered.

Width and address rules:
- wr_ptr is ADDR_W+1 bits wide.
- mem_addr takes wr_ptr[ADDR_W-1:0]. The clamp guarantees no wrap.
- Loading DEPTH words writes addresses 0..DEPTH-1 exactly once.

Optional Feature:
- IMEM_LOAD_CHECKSUM_EN defined:
  - ld_checksum is a running 32-bit modular sum of every accepted ld_data word in the current load.
  - It is cleared on ld_start and holds its value after ld_done until the next ld_start.
- IMEM_LOAD_CHECKSUM_EN not defined:
  - ld_checksum is tied to 0 and no adder is synthesised.

Test Plan:
- Fetch after reset: memory preloaded with word[5]=32'h2001_0003; fetch_req=1, fetch_addr=5 -> fetch_gnt=1 the same cycle; next cycle fetch_valid=1 and fetch_data=32'h2001_0003.
- Load 3 words: ld_start with ld_len=3, then data A,B,C with a one-cycle ld_valid gap after B -> writes land at addresses 0,1,2; cpu_stall stays high throughout; one cycle after C is accepted, ld_done=1 and cpu_restart=1; then RUN, and a fetch of address 1 returns B.
- Collision: ld_start=1 and fetch_req=1 in the same cycle -> fetch_gnt=0 and the next state is LOAD.
- ld_len=0 -> FLUSH on the next cycle with ld_done=1 and no mem_we asserted. Separately, ld_len=1100 -> clamped to 1024; the last write is at address 1023, then FLUSH.
- rst asserted after 2 of 5 words are accepted -> next cycle state is RUN, cpu_stall=0, no cpu_restart, and words 0-1 remain in memory.
- With IMEM_LOAD_CHECKSUM_EN defined, load 32'hFFFF_FFFF then 32'h0000_0002 -> ld_checksum=32'h0000_0001. With it undefined, ld_checksum stays 0.

Source files
------------

// File: rtl/imem_load_arbiter.sv
// ---------------------------------------------------------------------------
// imem_load_arbiter
//
// Owns the single instruction-memory port and shares it between the pipeline
// fetch stage (reads) and a program loader (word-by-word writes). A reload
// stalls the CPU, streams words into memory from address 0, then spends one
// FLUSH cycle pulsing ld_done and cpu_restart so the pipeline refetches from
// PC 0. The memory array reads combinationally; this block registers the
// read data so fetch latency is exactly one cycle.
//
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN
//   defined     -> ld_checksum is a running modular sum of the accepted words
//                  of the current load (cleared on ld_start, held afterwards)
//   not defined -> ld_checksum is tied to 0
//
// Handshakes:
//   fetch: fetch_req/fetch_gnt is a same-cycle request/grant; fetch_valid
//          with fetch_data follows exactly one cycle after each grant.
//   load : a word transfers on every cycle where ld_valid && ld_ready are
//          both high; ld_valid may drop at any time and simply stalls.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   fetch_req/addr/gnt/valid/data    IF-stage read port
//   cpu_stall, cpu_restart           pipeline hold and restart pulse
//   ld_start/len/valid/data/ready    loader command and data stream
//   ld_done, ld_checksum             completion pulse and optional sum
//   mem_addr/we/wdata/rdata          instruction memory port
//   dbg_state                        current FSM state (RUN/LOAD/FLUSH)
// ---------------------------------------------------------------------------
module imem_load_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   output logic              cpu_stall,
   output logic              cpu_restart,
   input  logic              ld_start,
   input  logic [ADDR_W:0]   ld_len,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              ld_done,
   output logic [DATA_W-1:0] ld_checksum,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              fetch_valid_q, fetch_valid_d;
   logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
   logic [ADDR_W:0]   len_clamped;
   logic [ADDR_W:0]   wr_ptr_inc;

   assign len_clamped = (ld_len > LEN_MAX) ? LEN_MAX : ld_len;
   assign wr_ptr_inc  = wr_ptr_q + PTR_ONE;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      len_d       = len_q;
      fetch_gnt   = 1'b0;
      cpu_stall   = 1'b0;
      cpu_restart = 1'b0;
      ld_ready    = 1'b0;
      ld_done     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = fetch_addr;
      mem_wdata   = ld_data;
      unique case (state_q)
         ST_RUN: begin
            // Loader wins a same-cycle collision with a fetch.
            fetch_gnt = fetch_req & ~ld_start;
            if (ld_start) begin
               len_d    = len_clamped;
               wr_ptr_d = '0;
               state_d  = (len_clamped == '0) ? ST_FLUSH : ST_LOAD;
            end
         end
         ST_LOAD: begin
            cpu_stall = 1'b1;
            ld_ready  = 1'b1;
            mem_addr  = wr_ptr_q[ADDR_W-1:0];
            mem_we    = ld_valid;
            if (ld_valid) begin
               wr_ptr_d = wr_ptr_inc;
               // The final word is written this cycle while we leave LOAD.
               if (wr_ptr_inc == len_q) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            cpu_stall   = 1'b1;
            ld_done     = 1'b1;
            cpu_restart = 1'b1;
            state_d     = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      // No grant outside RUN, so fetch_valid is already low on the first
      // RUN cycle after FLUSH.
      fetch_valid_d = fetch_gnt;
      fetch_data_d  = fetch_gnt ? mem_rdata : fetch_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         wr_ptr_q      <= '0;
         len_q         <= '0;
         fetch_valid_q <= 1'b0;
         fetch_data_q  <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         len_q         <= len_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_data_q  <= fetch_data_d;
      end
   end

   assign fetch_valid = fetch_valid_q;
   assign fetch_data  = fetch_data_q;
   assign dbg_state   = state_q;

`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (state_q == ST_RUN && ld_start) begin
         csum_d = '0;
      end else if (state_q == ST_LOAD && ld_valid) begin
         csum_d = csum_q + ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) csum_q <= '0;
      else     csum_q <= csum_d;
   end

   assign ld_checksum = csum_q;
`else
   assign ld_checksum = '0;
`endif

endmodule

// File: tb/tb_imem_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_load_arbiter
//
// Directed bench for imem_load_arbiter. A behavioural memory array sits on
// the mem_* port (combinational read, write on the rising edge). Inputs are
// driven 1 ns after the rising edge and outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_imem_load_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam logic [31:0] EXP_CSUM = 32'h0000_0001;
`else
  localparam logic [31:0] EXP_CSUM = 32'h0000_0000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              cpu_stall;
  logic              cpu_restart;
  logic              ld_start;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic [DATA_W-1:0] ld_checksum;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] tb_mem [0:DEPTH-1] = '{default: '0};
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (mem_we)      tb_mem[mem_addr] <= mem_wdata;
    else if (pre_we) tb_mem[pre_addr] <= pre_data;
  end
  assign mem_rdata = tb_mem[mem_addr];

  imem_load_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .cpu_stall(cpu_stall), .cpu_restart(cpu_restart),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
    .ld_checksum(ld_checksum),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    tick();
    tick();
    checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_RUN); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid: got %b exp 0", fetch_valid); end
    checks++; if (fetch_data !== 32'h0) begin errors++; $display("FAIL reset_fetch_data: got %h exp 0", fetch_data); end
    checks++; if (fetch_gnt !== 1'b0) begin errors++; $display("FAIL reset_fetch_gnt: got %b exp 0", fetch_gnt); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall: got %b exp 0", cpu_stall); end
    checks++; if (cpu_restart !== 1'b0) begin errors++; $display("FAIL reset_cpu_restart: got %b exp 0", cpu_restart); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b exp 0", ld_ready); end
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL reset_ld_done: got %b exp 0", ld_done); end
    checks++; if (ld_checksum !== 32'h0) begin errors++; $display("FAIL reset_checksum: got %h exp 0", ld_checksum); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b exp 0", mem_we); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    preload(10'd5, 32'h2001_0003);
    fetch_req = 1'b1; fetch_addr = 10'd5;
    #1;
    checks++; if (fetch_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt: got %b exp 1", fetch_gnt); end
    checks++; if (mem_addr !== 10'd5) begin errors++; $display("FAIL fetch_mem_addr: got %0d exp 5", mem_addr); end
    tick();
    fetch_req = 1'b0;
    #1;
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b exp 1", fetch_valid); end
    checks++; if (fetch_data !== 32'h2001_0003) begin errors++; $display("FAIL fetch_data: got %h exp 20010003", fetch_data); end
    tick();
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_drop: got %b exp 0", fetch_valid); end
    checks++; if (fetch_data !== 32'h2001_0003) begin errors++; $display("FAIL fetch_data_hold: got %h exp 20010003", fetch_data); end
  endtask

  task automatic test_load3();
    ld_len = 11'd3; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hAAAA_0001;
    #1;
    checks++; if (dbg_state !== ST_LOAD) begin errors++; $display("FAIL load3_state: got %0d exp %0d", dbg_state, ST_LOAD); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load3_stall_a: got %b exp 1", cpu_stall); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load3_ready: got %b exp 1", ld_ready); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL load3_we_a: got %b exp 1", mem_we); end
    checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL load3_addr_a: got %0d exp 0", mem_addr); end
    tick();
    ld_data = 32'hBBBB_0002;
    #1;
    checks++; if (mem_addr !== 10'd1) begin errors++; $display("FAIL load3_addr_b: got %0d exp 1", mem_addr); end
    tick();
    ld_valid = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL load3_we_gap: got %b exp 0", mem_we); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load3_stall_gap: got %b exp 1", cpu_stall); end
    checks++; if (dbg_state !== ST_LOAD) begin errors++; $display("FAIL load3_state_gap: got %0d exp %0d", dbg_state, ST_LOAD); end
    tick();
    ld_valid = 1'b1; ld_data = 32'hCCCC_0003;
    #1;
    checks++; if (mem_addr !== 10'd2) begin errors++; $display("FAIL load3_addr_c: got %0d exp 2", mem_addr); end
    tick();
    ld_valid = 1'b0;
    #1;
    checks++; if (dbg_state !== ST_FLUSH) begin errors++; $display("FAIL load3_flush: got %0d exp %0d", dbg_state, ST_FLUSH); end
    checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL load3_done: got %b exp 1", ld_done); end
    checks++; if (cpu_restart !== 1'b1) begin errors++; $display("FAIL load3_restart: got %b exp 1", cpu_restart); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load3_stall_flush: got %b exp 1", cpu_stall); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL load3_ready_flush: got %b exp 0", ld_ready); end
    checks++; if (tb_mem[0] !== 32'hAAAA_0001) begin errors++; $display("FAIL load3_mem0: got %h exp aaaa0001", tb_mem[0]); end
    checks++; if (tb_mem[1] !== 32'hBBBB_0002) begin errors++; $display("FAIL load3_mem1: got %h exp bbbb0002", tb_mem[1]); end
    checks++; if (tb_mem[2] !== 32'hCCCC_0003) begin errors++; $display("FAIL load3_mem2: got %h exp cccc0003", tb_mem[2]); end
    tick();
    checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL load3_run: got %0d exp %0d", dbg_state, ST_RUN); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL load3_stall_run: got %b exp 0", cpu_stall); end
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL load3_done_pulse: got %b exp 0", ld_done); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL load3_no_stale: got %b exp 0", fetch_valid); end
    fetch_req = 1'b1; fetch_addr = 10'd1;
    tick();
    fetch_req = 1'b0;
    #1;
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL load3_refetch_valid: got %b exp 1", fetch_valid); end
    checks++; if (fetch_data !== 32'hBBBB_0002) begin errors++; $display("FAIL load3_refetch_data: got %h exp bbbb0002", fetch_data); end
    tick();
  endtask

  task automatic test_collision();
    ld_len = 11'd2; ld_start = 1'b1;
    fetch_req = 1'b1; fetch_addr = 10'd5;
    #1;
    checks++; if (fetch_gnt !== 1'b0) begin errors++; $display("FAIL coll_gnt: got %b exp 0", fetch_gnt); end
    tick();
    ld_start = 1'b0; fetch_req = 1'b0;
    #1;
    checks++; if (dbg_state !== ST_LOAD) begin errors++; $display("FAIL coll_state: got %0d exp %0d", dbg_state, ST_LOAD); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL coll_valid: got %b exp 0", fetch_valid); end
    checks++; if (ld_checksum !== 32'h0) begin errors++; $display("FAIL coll_csum_clear: got %h exp 0", ld_checksum); end
    ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF;
    tick();
    ld_data = 32'h0000_0002;
    tick();
    ld_valid = 1'b0;
    #1;
    checks++; if (dbg_state !== ST_FLUSH) begin errors++; $display("FAIL coll_flush: got %0d exp %0d", dbg_state, ST_FLUSH); end
    checks++; if (ld_checksum !== EXP_CSUM) begin errors++; $display("FAIL csum_done: got %h exp %h", ld_checksum, EXP_CSUM); end
    tick();
    checks++; if (ld_checksum !== EXP_CSUM) begin errors++; $display("FAIL csum_hold: got %h exp %h", ld_checksum, EXP_CSUM); end
  endtask

  task automatic test_len_zero();
    ld_len = 11'd0; ld_start = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL len0_we_start: got %b exp 0", mem_we); end
    tick();
    ld_start = 1'b0;
    #1;
    checks++; if (dbg_state !== ST_FLUSH) begin errors++; $display("FAIL len0_flush: got %0d exp %0d", dbg_state, ST_FLUSH); end
    checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b exp 1", ld_done); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL len0_we: got %b exp 0", mem_we); end
    tick();
    checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL len0_run: got %0d exp %0d", dbg_state, ST_RUN); end
  endtask

  task automatic test_clamp();
    int bad;
    bad = 0;
    ld_len = 11'd1100; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1; ld_data = 32'hC000_0000 | i;
      #1;
      if (mem_addr !== 10'(i) || dbg_state !== ST_LOAD || mem_we !== 1'b1) bad++;
      tick();
    end
    ld_valid = 1'b0;
    #1;
    checks++; if (bad !== 0) begin errors++; $display("FAIL clamp_stream: got %0d bad cycles exp 0", bad); end
    checks++; if (dbg_state !== ST_FLUSH) begin errors++; $display("FAIL clamp_flush: got %0d exp %0d", dbg_state, ST_FLUSH); end
    checks++; if (tb_mem[0] !== 32'hC000_0000) begin errors++; $display("FAIL clamp_mem0: got %h exp c0000000", tb_mem[0]); end
    checks++; if (tb_mem[1023] !== 32'hC000_03FF) begin errors++; $display("FAIL clamp_mem1023: got %h exp c00003ff", tb_mem[1023]); end
    tick();
    checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL clamp_run: got %0d exp %0d", dbg_state, ST_RUN); end
  endtask

  task automatic test_reset_mid_load();
    ld_len = 11'd5; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hD000_0000;
    tick();
    ld_data = 32'hD000_0001;
    tick();
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL rstmid_state: got %0d exp %0d", dbg_state, ST_RUN); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b exp 0", cpu_stall); end
    checks++; if (cpu_restart !== 1'b0) begin errors++; $display("FAIL rstmid_restart: got %b exp 0", cpu_restart); end
    checks++; if (tb_mem[0] !== 32'hD000_0000) begin errors++; $display("FAIL rstmid_mem0: got %h exp d0000000", tb_mem[0]); end
    checks++; if (tb_mem[1] !== 32'hD000_0001) begin errors++; $display("FAIL rstmid_mem1: got %h exp d0000001", tb_mem[1]); end
    checks++; if (tb_mem[2] !== 32'hC000_0002) begin errors++; $display("FAIL rstmid_mem2: got %h exp c0000002", tb_mem[2]); end
    tick();
    checks++; if (cpu_restart !== 1'b0) begin errors++; $display("FAIL rstmid_restart_late: got %b exp 0", cpu_restart); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fetch();
    test_load3();
    test_collision();
    test_len_zero();
    test_clamp();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
